reaction_core: RTL and testbench



---
 rtl/reaction_core.sv | 200 ++++++++++++++++++++
 tb/tb_reaction_core.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_core.sv
// rtl/reaction_core.sv - parametrised press-the-indicated-key reaction game engine
module reaction_core #(
   parameter int NKEYS     = 6,
   parameter int NDIG      = 2,
   parameter int START_WIN = 99,
   parameter int MIN_WIN   = 10,
   parameter int STEP      = 1,
   parameter int LIVES     = 3,
   parameter int START_KEY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NKEYS-1:0]  keys,
   output logic [1:0]        state,
   output logic [3:0]        target,
   output logic [4*NDIG-1:0] time_now,
   output logic [4*NDIG-1:0] window,
   output logic [4*NDIG-1:0] score,
   output logic [2:0]        lives,
   output logic              hit,
   output logic              miss
);
   localparam int W = 4*NDIG;

   // One spare digit so MIN_WIN+STEP may exceed the displayable range.
   function automatic logic [W+3:0] to_bcd(input int v);
      logic [W+3:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i <= NDIG; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_sub(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      int d;
      int br;
      r  = '0;
      br = 0;
      for (int i = 0; i < NDIG; i++) begin
         d  = int'(a[4*i +: 4]) - int'(b[4*i +: 4]) - br;
         br = (d < 0) ? 1 : 0;
         if (d < 0) d = d + 10;
         r[4*i +: 4] = 4'(d);
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] a);
      logic [W-1:0] r;
      logic c;
      r = a;
      c = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
            else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   localparam logic [W+3:0] START_X  = to_bcd(START_WIN);
   localparam logic [W+3:0] MIN_X    = to_bcd(MIN_WIN);
   localparam logic [W+3:0] STEP_X   = to_bcd(STEP);
   localparam logic [W+3:0] FLOOR_X  = to_bcd(MIN_WIN + STEP);
   localparam logic [W-1:0] ALL9     = {NDIG{4'h9}};
   localparam logic [W-1:0] ONE_BCD  = W'(1);

   typedef enum logic [1:0] {S_IDLE = 2'b00, S_PLAY = 2'b01, S_OVER = 2'b10} state_t;

   state_t           cur, nxt;
   logic [NKEYS-1:0] s1, ks, kp, rise;
   logic [7:0]       lfsr;
   logic [3:0]       n_set, one, idx, base, cand;
   logic             evt, lose;
   logic [W-1:0]     win_dec, n_time, n_window, n_score;
   logic [3:0]       n_target;
   logic [2:0]       n_lives;
   logic             n_hit, n_miss;

   assign rise  = ks & ~kp;
   assign state = cur;

   // Several keys rising together decode to index 0, which never matches a target.
   always_comb begin
      n_set = '0;
      one   = '0;
      for (int i = 0; i < NKEYS; i++) begin
         if (rise[i]) begin
            n_set = n_set + 4'd1;
            one   = 4'(i + 1);
         end
      end
      evt = (n_set != 4'd0);
      idx = (n_set == 4'd1) ? one : 4'd0;
   end

   always_comb begin
      base = 4'((32'(lfsr) % 32'(NKEYS)) + 32'd1);
      cand = base;
      if (base == target) cand = (base == 4'(NKEYS)) ? 4'd1 : base + 4'd1;
   end

   assign win_dec = ({4'h0, window} >= FLOOR_X) ? bcd_sub(window, STEP_X[W-1:0]) : MIN_X[W-1:0];

   always_comb begin
      nxt      = cur;
      n_target = target;
      n_time   = time_now;
      n_window = window;
      n_score  = score;
      n_lives  = lives;
      n_hit    = 1'b0;
      n_miss   = 1'b0;
      lose     = 1'b0;
      case (cur)
         S_IDLE: begin
            if (evt && idx == 4'(START_KEY)) begin
               nxt      = S_PLAY;
               n_target = cand;
               n_time   = window;
            end
         end
         S_PLAY: begin
            if (evt && idx == target) begin
               n_score  = (score == ALL9) ? score : bcd_inc(score);
               n_window = win_dec;
               n_time   = win_dec;
               n_target = cand;
               n_hit    = 1'b1;
            end else if (evt || time_now == '0) begin
               lose = 1'b1;
            end else begin
               n_time = bcd_sub(time_now, ONE_BCD);
            end
            if (lose) begin
               n_miss  = 1'b1;
               n_lives = lives - 3'd1;
               if (lives == 3'd1) begin
                  nxt      = S_OVER;
                  n_target = 4'd0;
                  n_time   = '0;
               end else begin
                  n_target = cand;
                  n_time   = window;
               end
            end
         end
         S_OVER: begin
            if (evt && idx == 4'(START_KEY)) begin
               nxt      = S_IDLE;
               n_target = 4'd0;
               n_time   = START_X[W-1:0];
               n_window = START_X[W-1:0];
               n_score  = '0;
               n_lives  = 3'(LIVES);
            end
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1       <= '0;
         ks       <= '0;
         kp       <= '0;
         lfsr     <= 8'h01;
         cur      <= S_IDLE;
         target   <= 4'd0;
         time_now <= START_X[W-1:0];
         window   <= START_X[W-1:0];
         score    <= '0;
         lives    <= 3'(LIVES);
         hit      <= 1'b0;
         miss     <= 1'b0;
      end else begin
         s1       <= keys;
         ks       <= s1;
         kp       <= ks;
         lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         cur      <= nxt;
         target   <= n_target;
         time_now <= n_time;
         window   <= n_window;
         score    <= n_score;
         lives    <= n_lives;
         hit      <= n_hit;
         miss     <= n_miss;
      end
   end
endmodule

// File: tb/tb_reaction_core.sv
// tb/tb_reaction_core.sv - scoreboard bench for reaction_core (default and short-window instances)
module tb_reaction_core;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] keys_a = '0, keys_b = '0;
   logic [1:0] state_a, state_b;
   logic [3:0] target_a, target_b;
   logic [7:0] time_a, win_a, score_a, time_b, win_b, score_b;
   logic [2:0] lives_a, lives_b;
   logic       hit_a, miss_a, hit_b, miss_b;
   int         total = 0;
   int         bad = 0;

   typedef struct {
      bit         is_hit;
      bit         over;
      logic [1:0] st;
      logic [7:0] sc;
      logic [7:0] win;
      logic [7:0] tm;
      logic [2:0] lv;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] m_lfsr, m_prev;
   logic [3:0] t_prev = 4'd0;

   reaction_core dut_a (
      .clk(clk), .rst(rst), .keys(keys_a), .state(state_a), .target(target_a),
      .time_now(time_a), .window(win_a), .score(score_a), .lives(lives_a),
      .hit(hit_a), .miss(miss_a)
   );

   reaction_core #(.NKEYS(6), .NDIG(2), .START_WIN(12), .MIN_WIN(10), .STEP(3),
                   .LIVES(3), .START_KEY(1)) dut_b (
      .clk(clk), .rst(rst), .keys(keys_b), .state(state_b), .target(target_b),
      .time_now(time_b), .window(win_b), .score(score_b), .lives(lives_b),
      .hit(hit_b), .miss(miss_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_lfsr <= 8'h01;
         m_prev <= 8'h01;
      end else begin
         m_prev <= m_lfsr;
         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end
   end

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) % 10) * 16 + (v % 10));
   endfunction

   function automatic logic [3:0] cand(input logic [7:0] l, input logic [3:0] t);
      int c;
      c = (int'(l) % 6) + 1;
      if (c == int'(t)) c = (c == 6) ? 1 : c + 1;
      return 4'(c);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic press(input bit b, input logic [5:0] m);
      @(posedge clk);
      #2;
      if (b) keys_b = m;
      else   keys_a = m;
      @(posedge clk);
      #2;
      keys_a = '0;
      keys_b = '0;
   endtask

   task automatic wait_pulse(input bit b, input int lim);
      int n;
      n = 0;
      while (n < lim && !(b ? (hit_b || miss_b) : (hit_a || miss_a))) begin
         @(negedge clk);
         #1;
         n++;
      end
      total++;
      if (!(b ? (hit_b || miss_b) : (hit_a || miss_a))) begin
         bad++;
         $display("FAIL pulse_wait: no hit/miss within %0d cycles (dut %0d)", lim, b);
      end
   endtask

   always begin
      @(negedge clk);
      if (!rst) begin
         if (hit_a || miss_a) begin
            chk("pulse_exclusive", 32'(hit_a && miss_a), 32'd0);
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_pulse: hit=%0b miss=%0b with nothing expected", hit_a, miss_a);
            end else begin
               chk("pulse_hit",    32'(hit_a),    32'(sbq[0].is_hit));
               chk("pulse_miss",   32'(miss_a),   32'(!sbq[0].is_hit));
               chk("pulse_state",  32'(state_a),  32'(sbq[0].st));
               chk("pulse_score",  32'(score_a),  32'(sbq[0].sc));
               chk("pulse_window", 32'(win_a),    32'(sbq[0].win));
               chk("pulse_time",   32'(time_a),   32'(sbq[0].tm));
               chk("pulse_lives",  32'(lives_a),  32'(sbq[0].lv));
               chk("pulse_target", 32'(target_a), 32'(sbq[0].over ? 4'd0 : cand(m_prev, t_prev)));
               if (!sbq[0].over) chk("target_differs", 32'(target_a != t_prev), 32'd1);
               sbq.delete(0);
            end
         end
         t_prev = target_a;
      end
   end

   initial begin
      int sc, lv, win, t;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_state",  32'(state_a),  32'd0);
      chk("rst_target", 32'(target_a), 32'd0);
      chk("rst_time",   32'(time_a),   32'h99);
      chk("rst_window", 32'(win_a),    32'h99);
      chk("rst_score",  32'(score_a),  32'h00);
      chk("rst_lives",  32'(lives_a),  32'd3);
      chk("rst_hit",    32'(hit_a),    32'd0);
      chk("rst_miss",   32'(miss_a),   32'd0);
      @(posedge clk);
      #2 rst = 1'b0;

      press(1'b0, 6'b001000);
      repeat (5) @(negedge clk);
      #1;
      chk("idle_state",  32'(state_a),  32'd0);
      chk("idle_target", 32'(target_a), 32'd0);
      chk("idle_time",   32'(time_a),   32'h99);

      // Start key held three cycles: state changes two edges after first sample.
      @(posedge clk);
      #2 keys_a = 6'b000001;
      repeat (3) @(negedge clk);
      #1;
      chk("start_not_early", 32'(state_a), 32'd0);
      @(negedge clk);
      #1;
      chk("start_state",  32'(state_a),  32'd1);
      chk("start_time",   32'(time_a),   32'h99);
      chk("start_target", 32'(target_a), 32'(cand(m_prev, 4'd0)));
      @(negedge clk);
      #1;
      chk("start_countdown", 32'(time_a), 32'h98);
      keys_a = '0;

      sc = 0; lv = 3; win = 99;
      for (int i = 0; i < 50; i++) begin
         t = int'(target_a);
         win = (win - 1 < 10) ? 10 : win - 1;
         sc++;
         sbq.push_back('{1'b1, 1'b0, 2'b01, bcd(sc), bcd(win), bcd(win), 3'(lv)});
         press(1'b0, 6'(1 << (t - 1)));
         wait_pulse(1'b0, 10);
      end

      for (int n = 1; n <= win; n++) begin
         @(negedge clk);
         #1;
         chk("countdown", 32'(time_a), 32'(bcd(win - n)));
      end
      chk("zero_no_miss_yet", 32'(miss_a), 32'd0);
      lv = 2;
      sbq.push_back('{1'b0, 1'b0, 2'b01, bcd(sc), bcd(win), bcd(win), 3'(lv)});
      wait_pulse(1'b0, 3);

      lv = 1;
      sbq.push_back('{1'b0, 1'b0, 2'b01, bcd(sc), bcd(win), bcd(win), 3'(lv)});
      press(1'b0, 6'b000110);
      wait_pulse(1'b0, 10);

      t = int'(target_a);
      lv = 0;
      sbq.push_back('{1'b0, 1'b1, 2'b10, bcd(sc), bcd(win), 8'h00, 3'(lv)});
      press(1'b0, 6'(1 << (t % 6)));
      wait_pulse(1'b0, 10);

      press(1'b0, 6'b000100);
      repeat (5) @(negedge clk);
      #1;
      chk("over_state",  32'(state_a),  32'd2);
      chk("over_target", 32'(target_a), 32'd0);
      chk("over_time",   32'(time_a),   32'h00);
      chk("over_lives",  32'(lives_a),  32'd0);
      chk("over_score",  32'(score_a),  32'(bcd(sc)));
      chk("over_window", 32'(win_a),    32'(bcd(win)));

      press(1'b0, 6'b000001);
      repeat (5) @(negedge clk);
      #1;
      chk("restart_state",  32'(state_a),  32'd0);
      chk("restart_target", 32'(target_a), 32'd0);
      chk("restart_time",   32'(time_a),   32'h99);
      chk("restart_window", 32'(win_a),    32'h99);
      chk("restart_score",  32'(score_a),  32'h00);
      chk("restart_lives",  32'(lives_a),  32'd3);

      press(1'b0, 6'b000001);
      repeat (5) @(negedge clk);
      #1;
      chk("replay_state", 32'(state_a), 32'd1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_state",  32'(state_a),  32'd0);
      chk("async_target", 32'(target_a), 32'd0);
      chk("async_time",   32'(time_a),   32'h99);
      @(negedge clk);
      #2 rst = 1'b0;

      press(1'b1, 6'b000001);
      repeat (4) @(negedge clk);
      #1;
      chk("b_start_state",  32'(state_b), 32'd1);
      chk("b_start_window", 32'(win_b),   32'h12);
      for (int i = 1; i <= 100; i++) begin
         t = int'(target_b);
         press(1'b1, 6'(1 << (t - 1)));
         wait_pulse(1'b1, 10);
         chk("b_hit",    32'(hit_b),   32'd1);
         chk("b_window", 32'(win_b),   32'h10);
         chk("b_score",  32'(score_b), 32'(bcd(i > 99 ? 99 : i)));
      end

      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
